// File: rtl/compute_clock_sequencer_pkg.sv
// Shared types for the compute clock sequencer: FSM states, completion status codes, default drain length.
package compute_clock_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RUN       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_REPORT    = 3'd4
  } seq_state_t;

  localparam logic [1:0] STATUS_COMPLETE  = 2'b00;
  localparam logic [1:0] STATUS_HALTED    = 2'b01;
  localparam logic [1:0] STATUS_ABORTED   = 2'b10;
  localparam logic [1:0] STATUS_LOCK_LOST = 2'b11;

  localparam int DRAIN_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/compute_clock_sequencer_stats.sv
// Saturating event counter: adds one per cycle while inc is high and holds at all-ones.
// Single-cycle update latency; never backpressures its source.
module clock_stats_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/compute_clock_sequencer.sv
// Runs the compute clock for N cycles once lock is present, stopping early on halt/abort/lock loss.
// Enable rises one cycle after accept; done_valid follows DRAIN_CYCLES after the enable drops.
// Requests are refused (req_ready low) while busy. Optional stats via COMPUTE_CLOCK_STATS_EN.
module compute_clock_sequencer
  import compute_clock_sequencer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_cycles,
  input  logic             halt,
  input  logic             abort,
  output logic             compute_clock_en,
  output logic             busy,
  output logic             done_valid,
  output logic [CNT_W-1:0] done_cycles,
  output logic [1:0]       done_status
`ifdef COMPUTE_CLOCK_STATS_EN
  ,
  output logic [63:0]      stat_total_cycles,
  output logic [31:0]      stat_runs
`endif
);

  seq_state_t       state, state_next;
  logic [1:0]       status_q, status_next;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] exec_inc;
  logic [7:0]       drain_cnt;
  logic             accept;

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign done_valid = (state == ST_REPORT);
  assign accept     = req_valid && req_ready;
  assign exec_inc   = exec_cnt + CNT_W'(1);

  always_comb begin
    state_next  = state;
    status_next = status_q;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          status_next = STATUS_COMPLETE;
          if (req_cycles == '0)  state_next = ST_REPORT;
          else if (locked)       state_next = ST_RUN;
          else                   state_next = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (abort) begin
          state_next  = ST_REPORT;
          status_next = STATUS_ABORTED;
        end else if (locked) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Exit conditions see the count including this cycle, in priority order.
        if (!locked) begin
          state_next  = ST_DRAIN;
          status_next = STATUS_LOCK_LOST;
        end else if (abort) begin
          state_next  = ST_DRAIN;
          status_next = STATUS_ABORTED;
        end else if (halt) begin
          state_next  = ST_DRAIN;
          status_next = STATUS_HALTED;
        end else if (exec_inc == target_q) begin
          state_next  = ST_DRAIN;
          status_next = STATUS_COMPLETE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == 8'(DRAIN_CYCLES - 1)) state_next = ST_REPORT;
      end
      ST_REPORT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      status_q         <= STATUS_COMPLETE;
      compute_clock_en <= 1'b0;
    end else begin
      state            <= state_next;
      status_q         <= status_next;
      compute_clock_en <= (state_next == ST_RUN);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target_q    <= '0;
      exec_cnt    <= '0;
      drain_cnt   <= '0;
      done_cycles <= '0;
      done_status <= STATUS_COMPLETE;
    end else begin
      if (accept) begin
        target_q  <= req_cycles;
        exec_cnt  <= '0;
        drain_cnt <= '0;
      end
      if (state == ST_RUN)   exec_cnt  <= exec_inc;
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + 8'd1;
      // A zero-length request reports straight from IDLE, before exec_cnt is cleared.
      if (state_next == ST_REPORT) begin
        done_cycles <= (state == ST_IDLE) ? '0 : exec_cnt;
        done_status <= status_next;
      end
    end
  end

`ifdef COMPUTE_CLOCK_STATS_EN
  clock_stats_counter #(.W(64)) u_stat_total (
    .clock (clock),
    .reset (reset),
    .inc   (compute_clock_en),
    .count (stat_total_cycles)
  );

  clock_stats_counter #(.W(32)) u_stat_runs (
    .clock (clock),
    .reset (reset),
    .inc   (done_valid),
    .count (stat_runs)
  );
`endif

endmodule
